// File: rtl/sfp_row_p.sv
// sfp_row_p: softmax-style row normaliser (abs-sum accumulate, sum FIFOs, 2-stage divide).
// Optional macro SFP_EXT_SUM_EN enables the partner-core path (external FIFO, sum_in, sum_out).
module sfp_row_p #(
    parameter int COL     = 8,
    parameter int BW_PSUM = 20,
    parameter int SUM_W   = BW_PSUM + 4,
    parameter int DEPTH   = 16,
    parameter int SHIFT   = 7
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     acc,
    input  logic                     div,
    input  logic                     fifo_ext_rd,
    input  logic [COL*BW_PSUM-1:0]   sfp_in,
    input  logic [SUM_W-1:0]         sum_in,
    output logic [COL*BW_PSUM-1:0]   sfp_out,
    output logic                     sfp_valid,
    output logic [SUM_W-1:0]         sum_out,
    output logic                     sum_out_valid,
    output logic                     int_empty,
    output logic                     int_full,
    output logic                     ext_empty,
    output logic                     ext_full,
    output logic                     ovf,
    output logic                     udf,
    output logic                     dz
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = SUM_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Magnitude as unsigned, so the most-negative input maps to 2^(BW_PSUM-1).
    function automatic logic [SUM_W-1:0] mag(input logic signed [BW_PSUM-1:0] x);
        logic [BW_PSUM-1:0] m;
        m = x[BW_PSUM-1] ? -x : x;
        return SUM_W'(m);
    endfunction

    function automatic logic signed [BW_PSUM-1:0] quot(input logic signed [BW_PSUM-1:0] x,
                                                       input logic [DW-1:0] d);
        logic signed [DW:0] num;
        logic signed [DW:0] den;
        num = (DW+1)'(x);
        den = $signed({1'b0, d});
        if (d == '0) return '0;
        return BW_PSUM'(num / den);
    endfunction

    logic [SUM_W-1:0]         total_d, total_p0, int_head;
    logic                     vld_p0, vld_p1, vld_p2, zero_p2;
    logic [DW-1:0]            sum_c, den_d, den_p1;
    logic [COL*BW_PSUM-1:0]   row_p1, quot_d, quot_p2, sfp_out_q;
    logic                     sfp_valid_q, ovf_q, udf_q, dz_q;
    logic                     ext_drop, ext_udf;

    logic [SUM_W-1:0]         int_mem [DEPTH];
    logic [AW-1:0]            int_wp_q, int_rp_q;
    logic [CW-1:0]            int_cnt_q, int_cnt_d;
    logic                     int_pop, int_push, int_drop, int_empty_q, int_full_q;

    always_comb begin
        total_d = '0;
        for (int i = 0; i < COL; i++) begin
            total_d = total_d + mag(sfp_in[i*BW_PSUM +: BW_PSUM]);
        end
    end

    // Push is taken from the registered total; a same-edge pop frees a slot, but never bypasses.
    assign int_pop   = div && (int_cnt_q != '0);
    assign int_push  = vld_p0 && ((int_cnt_q < DEPTH_C) || int_pop);
    assign int_drop  = vld_p0 && !int_push;
    assign int_cnt_d = int_cnt_q + CW'(int_push) - CW'(int_pop);
    assign int_head  = int_mem[int_rp_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_wp_q    <= '0;
            int_rp_q    <= '0;
            int_cnt_q   <= '0;
            int_empty_q <= 1'b1;
            int_full_q  <= 1'b0;
        end else begin
            if (int_push) int_wp_q <= int_wp_q + AW'(1);
            if (int_pop)  int_rp_q <= int_rp_q + AW'(1);
            int_cnt_q   <= int_cnt_d;
            int_empty_q <= (int_cnt_d == '0);
            int_full_q  <= (int_cnt_d == DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (int_push) int_mem[int_wp_q] <= total_p0;
    end

`ifdef SFP_EXT_SUM_EN
    logic [SUM_W-1:0]         ext_mem [DEPTH];
    logic [AW-1:0]            ext_wp_q, ext_rp_q;
    logic [CW-1:0]            ext_cnt_q, ext_cnt_d;
    logic                     ext_pop, ext_push, ext_empty_q, ext_full_q, sum_out_valid_q;
    logic [SUM_W-1:0]         sum_out_q;

    assign sum_c     = {1'b0, int_head} + {1'b0, sum_in};
    assign ext_pop   = fifo_ext_rd && (ext_cnt_q != '0);
    assign ext_push  = vld_p0 && ((ext_cnt_q < DEPTH_C) || ext_pop);
    assign ext_drop  = vld_p0 && !ext_push;
    assign ext_udf   = fifo_ext_rd && !ext_pop;
    assign ext_cnt_d = ext_cnt_q + CW'(ext_push) - CW'(ext_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_wp_q        <= '0;
            ext_rp_q        <= '0;
            ext_cnt_q       <= '0;
            ext_empty_q     <= 1'b1;
            ext_full_q      <= 1'b0;
            sum_out_q       <= '0;
            sum_out_valid_q <= 1'b0;
        end else begin
            if (ext_push) ext_wp_q <= ext_wp_q + AW'(1);
            if (ext_pop) begin
                ext_rp_q  <= ext_rp_q + AW'(1);
                sum_out_q <= ext_mem[ext_rp_q];
            end
            ext_cnt_q       <= ext_cnt_d;
            ext_empty_q     <= (ext_cnt_d == '0);
            ext_full_q      <= (ext_cnt_d == DEPTH_C);
            sum_out_valid_q <= ext_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (ext_push) ext_mem[ext_wp_q] <= total_p0;
    end

    assign sum_out       = sum_out_q;
    assign sum_out_valid = sum_out_valid_q;
    assign ext_empty     = ext_empty_q;
    assign ext_full      = ext_full_q;
`else
    logic unused_ext;
    assign unused_ext    = ^{fifo_ext_rd, sum_in};
    assign sum_c         = {1'b0, int_head};
    assign ext_drop      = 1'b0;
    assign ext_udf       = 1'b0;
    assign sum_out       = '0;
    assign sum_out_valid = 1'b0;
    assign ext_empty     = 1'b1;
    assign ext_full      = 1'b0;
`endif

    assign den_d = sum_c >> SHIFT;

    always_comb begin
        quot_d = '0;
        for (int i = 0; i < COL; i++) begin
            quot_d[i*BW_PSUM +: BW_PSUM] = quot(row_p1[i*BW_PSUM +: BW_PSUM], den_p1);
        end
    end

    // Datapath registers: qualified by the valids, so they need no reset.
    always_ff @(posedge clk) begin
        if (acc) total_p0 <= total_d;
        if (int_pop) begin
            den_p1 <= den_d;
            row_p1 <= sfp_in;
        end
        if (vld_p1) begin
            quot_p2 <= quot_d;
            zero_p2 <= (den_p1 == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            sfp_valid_q <= 1'b0;
            sfp_out_q   <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            vld_p0      <= acc;
            vld_p1      <= int_pop;
            vld_p2      <= vld_p1;
            sfp_valid_q <= vld_p2;
            if (vld_p2) sfp_out_q <= quot_p2;
            if (int_drop || ext_drop) ovf_q <= 1'b1;
            if ((div && !int_pop) || ext_udf) udf_q <= 1'b1;
            if (vld_p2 && zero_p2) dz_q <= 1'b1;
        end
    end

    assign sfp_out   = sfp_out_q;
    assign sfp_valid = sfp_valid_q;
    assign int_empty = int_empty_q;
    assign int_full  = int_full_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;
    assign dz        = dz_q;
endmodule

// File: tb/tb_sfp_row_p.sv
// Directed bench for sfp_row_p: vector table for the divide path plus hand sequences.
module tb_sfp_row_p;
    localparam int COL   = 8;
    localparam int BW    = 20;
    localparam int SW    = 24;
    localparam int DEPTH = 16;
    localparam int SHIFT = 7;

`ifdef SFP_EXT_SUM_EN
    localparam int   SI_X0       = 10;
    localparam int   SI_X1       = -10;
    localparam logic EE_AFTER    = 1'b0;
    localparam logic OVF_AT_POP  = 1'b1;
    localparam logic EXT_FULL_16 = 1'b1;
`else
    localparam int   SI_X0       = 20;
    localparam int   SI_X1       = -20;
    localparam logic EE_AFTER    = 1'b1;
    localparam logic OVF_AT_POP  = 1'b0;
    localparam logic EXT_FULL_16 = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset_n, acc, div, fifo_ext_rd;
    logic [COL*BW-1:0]   sfp_in, sfp_out;
    logic [SW-1:0]       sum_in, sum_out;
    logic                sfp_valid, sum_out_valid;
    logic                int_empty, int_full, ext_empty, ext_full, ovf, udf, dz;
    int                  n_chk = 0;
    int                  n_fail = 0;

    typedef struct {
        int a;
        int e0;
        int e1;
        int x0;
        int x1;
    } vec_t;
    vec_t tbl[6];

    logic [SW-1:0] exp_so[4];
    logic          exp_sv[4];
    logic          exp_udf[4];

    always #5 clk = ~clk;

    sfp_row_p #(.COL(COL), .BW_PSUM(BW), .SUM_W(SW), .DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset_n(reset_n), .acc(acc), .div(div), .fifo_ext_rd(fifo_ext_rd),
        .sfp_in(sfp_in), .sum_in(sum_in), .sfp_out(sfp_out), .sfp_valid(sfp_valid),
        .sum_out(sum_out), .sum_out_valid(sum_out_valid), .int_empty(int_empty),
        .int_full(int_full), .ext_empty(ext_empty), .ext_full(ext_full),
        .ovf(ovf), .udf(udf), .dz(dz)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [COL*BW-1:0] act, input logic [COL*BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [COL*BW-1:0] row_all(input int v);
        logic [COL*BW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(v);
        return r;
    endfunction

    function automatic logic [COL*BW-1:0] row2(input int e0, input int e1);
        logic [COL*BW-1:0] r;
        r = '0;
        r[0 +: BW]  = BW'(e0);
        r[BW +: BW] = BW'(e1);
        return r;
    endfunction

    task automatic do_acc(input int v);
        sfp_in = row_all(v);
        acc = 1'b1;
        tick;
        acc = 1'b0;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        acc = 1'b0;
        div = 1'b0;
        fifo_ext_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{128, 160, -160, 20, -20};
        tbl[1] = '{-256, 1000, -1000, 62, -62};
        tbl[2] = '{16, 524287, -524288, 524287, -524288};
        tbl[3] = '{-524288, 100000, -65536, 3, -2};
        tbl[4] = '{1000, -7, 125, 0, 2};
        tbl[5] = '{3000, -374, -373, -2, -1};
`ifdef SFP_EXT_SUM_EN
        exp_so  = '{24'd128, 24'd256, 24'd384, 24'd384};
        exp_sv  = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_udf = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_so  = '{24'd0, 24'd0, 24'd0, 24'd0};
        exp_sv  = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_udf = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        reset_n = 1'b0; acc = 1'b0; div = 1'b0; fifo_ext_rd = 1'b0;
        sfp_in = '0; sum_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sfp_out", sfp_out, '0);
        chk("rst_valids", {sfp_valid, sum_out_valid}, '0);
        chk("rst_sum_out", sum_out, '0);
        chk("rst_empty", {int_empty, ext_empty}, 2'b11);
        chk("rst_full", {int_full, ext_full}, '0);
        chk("rst_flags", {ovf, udf, dz}, '0);
        reset_n = 1'b1;
        tick;

        // Divide path over the vector table.
        for (int k = 0; k < 6; k++) begin
            do_acc(tbl[k].a);
            tick;
            chk("vec_nonempty", int_empty, 1'b0);
            sfp_in = row2(tbl[k].e0, tbl[k].e1);
            sum_in = '0;
            div = 1'b1;
            tick;
            div = 1'b0;
            chk("vec_empty_after_pop", int_empty, 1'b1);
            sfp_in = '1;
            tick;
            chk("vec_valid_early", sfp_valid, 1'b0);
            tick;
            chk("vec_valid", sfp_valid, 1'b1);
            chk("vec_data", sfp_out, row2(tbl[k].x0, tbl[k].x1));
            tick;
            chk("vec_valid_pulse", sfp_valid, 1'b0);
            chk("vec_hold", sfp_out, row2(tbl[k].x0, tbl[k].x1));
        end
        chk("vec_flags", {ovf, udf, dz}, '0);

        // Partner sum contributes to the divisor only when enabled.
        do_acc(128);
        tick;
        sfp_in = row2(160, -160);
        sum_in = 24'd1024;
        div = 1'b1;
        tick;
        div = 1'b0;
        sum_in = '0;
        tick;
        tick;
        chk("sumin_valid", sfp_valid, 1'b1);
        chk("sumin_data", sfp_out, row2(SI_X0, SI_X1));

        // Fill to full, push-with-pop when full, dropped push, then drain past empty.
        do_reset;
        sfp_in = row_all(128);
        for (int k = 0; k < 17; k++) begin
            acc = 1'b1;
            tick;
            if (k == 15) chk("fill_not_full", int_full, 1'b0);
            if (k == 16) chk("fill_full", int_full, 1'b1);
        end
        chk("fill_no_ovf", ovf, 1'b0);
        chk("fill_ext_full", ext_full, EXT_FULL_16);
        sfp_in = row2(160, -160);
        div = 1'b1;
        tick;
        chk("full_push_pop_full", int_full, 1'b1);
        chk("full_push_pop_ovf", ovf, OVF_AT_POP);
        acc = 1'b0;
        div = 1'b0;
        tick;
        chk("full_drop_ovf", ovf, 1'b1);
        chk("full_drop_still_full", int_full, 1'b1);
        for (int j = 0; j < 19; j++) begin
            div = (j < 17);
            tick;
            chk("drain_valid", sfp_valid, (j == 0 || (j >= 2 && j <= 17)));
            if (j == 0 || (j >= 2 && j <= 17)) chk("drain_data", sfp_out, row2(20, -20));
            chk("drain_udf", udf, (j >= 16));
            chk("drain_empty", int_empty, (j >= 15));
        end
        div = 1'b0;

        // Zero divisor, then a good divisor: dz stays sticky.
        do_reset;
        do_acc(8);
        tick;
        sfp_in = row2(100, -5);
        div = 1'b1;
        tick;
        div = 1'b0;
        tick;
        chk("dz_not_yet", sfp_valid, 1'b0);
        tick;
        chk("dz_valid", sfp_valid, 1'b1);
        chk("dz_data", sfp_out, '0);
        chk("dz_flag", dz, 1'b1);
        do_acc(128);
        tick;
        sfp_in = row2(160, -160);
        div = 1'b1;
        tick;
        div = 1'b0;
        tick;
        tick;
        chk("dz_after_data", sfp_out, row2(20, -20));
        chk("dz_sticky", dz, 1'b1);

        // Concurrent acc/div keeps one entry in flight; FIFO order a, b, c.
        sfp_in = row_all(128);
        acc = 1'b1;
        tick;
        sfp_in = row_all(256);
        tick;
        chk("conc_e2_nonempty", int_empty, 1'b0);
        sfp_in = row_all(384);
        div = 1'b1;
        tick;
        chk("conc_e3_nonempty", int_empty, 1'b0);
        acc = 1'b0;
        sfp_in = row_all(480);
        tick;
        chk("conc_e4_nonempty", int_empty, 1'b0);
        tick;
        div = 1'b0;
        chk("conc_e5_empty", int_empty, 1'b1);
        chk("conc_out_a", {sfp_valid, sfp_out}, {1'b1, row_all(48)});
        tick;
        chk("conc_out_b", {sfp_valid, sfp_out}, {1'b1, row_all(30)});
        tick;
        chk("conc_out_c", {sfp_valid, sfp_out}, {1'b1, row_all(20)});
        tick;
        chk("conc_end_valid", sfp_valid, 1'b0);
        chk("conc_flags", {ovf, udf}, '0);

        // External drain: three entries then one pop on empty.
        do_reset;
        do_acc(16);
        do_acc(32);
        do_acc(48);
        tick;
        chk("ext_empty_after_push", ext_empty, EE_AFTER);
        fifo_ext_rd = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick;
            chk("ext_sum_out", sum_out, exp_so[j]);
            chk("ext_sum_valid", sum_out_valid, exp_sv[j]);
            chk("ext_udf", udf, exp_udf[j]);
        end
        fifo_ext_rd = 1'b0;
        tick;
        chk("ext_valid_clear", sum_out_valid, 1'b0);

        // Reset asserted between a divide and its output.
        do_reset;
        div = 1'b1;
        tick;
        div = 1'b0;
        chk("rm_empty_div_udf", udf, 1'b1);
        do_acc(128);
        do_acc(128);
        tick;
        sfp_in = row2(160, -160);
        div = 1'b1;
        tick;
        tick;
        div = 1'b0;
        tick;
        chk("rm_first_out", {sfp_valid, sfp_out}, {1'b1, row2(20, -20)});
        #2 reset_n = 1'b0;
        #1;
        chk("rm_async_out", {sfp_valid, sfp_out}, '0);
        chk("rm_async_state", {int_empty, int_full, ovf, udf, dz}, 5'b10000);
        chk("rm_async_sum", {sum_out_valid, sum_out}, '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick;
            chk("rm_no_valid", {sfp_valid, sfp_out}, '0);
        end
        chk("rm_flags", {ovf, udf, dz, int_empty}, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
